// File: rtl/phase_nco.sv
// Phase accumulator NCO with linear frequency chirp; emits 16-bit Furman angles
// over a valid/ready handshake as a counted burst or a continuous stream.
//
// state | meaning
// IDLE  | configuration writable, waiting for start
// RUN   | presenting angle samples, config frozen
module phase_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             cfg_we,
    input  logic [ACC_W-1:0] cfg_freq,
    input  logic [ACC_W-1:0] cfg_chirp,
    input  logic [15:0]      cfg_phase,
    input  logic [15:0]      cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic [15:0]      angle,
    output logic             angle_valid,
    input  logic             angle_ready,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_freq_cfg;
    logic [ACC_W-1:0] r_chirp_cfg;
    logic [15:0]      r_phase_cfg;
    logic [15:0]      r_count_cfg;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_freq;
    logic [15:0]      r_remaining;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_run;
    logic             w_hs;
    logic             w_last;
    logic             w_launch;
    logic [15:0]      w_acc_top;

    assign w_run     = (r_state == RUN);
    assign w_hs      = w_run && angle_ready;
    assign w_last    = w_run && (r_count_cfg != 16'd0) && (r_remaining == 16'd1);
    assign w_launch  = (r_state == IDLE) && start;
    assign w_acc_top = r_acc[ACC_W-1 -: 16];

    assign angle       = w_run ? (w_acc_top + r_phase_cfg) : 16'd0;
    assign angle_valid = w_run;
    assign last        = w_last;
    assign busy        = w_run;
    assign done        = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                // stop wins over a final handshake, so an aborted burst never reports done
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_hs && w_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_freq_cfg  <= '0;
            r_chirp_cfg <= '0;
            r_phase_cfg <= '0;
            r_count_cfg <= '0;
        end else if ((r_state == IDLE) && cfg_we) begin
            r_freq_cfg  <= cfg_freq;
            r_chirp_cfg <= cfg_chirp;
            r_phase_cfg <= cfg_phase;
            r_count_cfg <= cfg_count;
        end
    end

    // A start coinciding with cfg_we takes the incoming values directly.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_acc       <= '0;
            r_freq      <= '0;
            r_remaining <= '0;
        end else if (w_launch) begin
            r_acc       <= '0;
            r_freq      <= cfg_we ? cfg_freq : r_freq_cfg;
            r_remaining <= cfg_we ? cfg_count : r_count_cfg;
        end else if (w_hs) begin
            r_acc  <= r_acc + r_freq;
            r_freq <= r_freq + r_chirp_cfg;
            if (r_count_cfg != 16'd0) r_remaining <= r_remaining - 16'd1;
        end
    end

endmodule
